// File: rtl/if_pkg.sv
// if_pkg: shared states, redirect/trap codes and buffer entry layout for the prefetching fetch stage.
package if_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;
  localparam logic [1:0] PC_CTRL_SEQ = 2'b00;
  localparam logic [1:0] PC_CTRL_JB = 2'b01;
  localparam logic [1:0] PC_CTRL_TRAP = 2'b10;
  localparam logic [3:0] TRAP_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] TRAP_INSTR_ACCESS_FAULT = 4'd1;
  localparam int ENTRY_W = 69;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        trap;
    logic [3:0]  code;
  } entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: synchronous FIFO with same-cycle flush and occupancy count.
module if_fetch_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  always_ff @(posedge clk_i)
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  assign dout = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: Wishbone instruction prefetcher feeding decode through a flushable buffer.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
  parameter int          FIFO_DEPTH       = 4,
  parameter bit          FETCH_EN_DEFAULT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_jb_i,
  input  logic [31:0] pc_trap_i,
  input  logic [1:0]  pc_control_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_if_o,
  output logic [31:0] pc4_if_o,
  output logic        is_trap_if_o,
  output logic [3:0]  trap_code_if_o,
  output logic [31:0] wbm_addr_if_o,
  output logic [31:0] wbm_dat_if_o,
  output logic [3:0]  wbm_sel_if_o,
  output logic        wbm_cyc_if_o,
  output logic        wbm_stb_if_o,
  output logic        wbm_we_if_o,
  input  logic [31:0] wbm_dat_if_i,
  input  logic        wbm_ack_if_i,
  input  logic        wbm_err_if_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [31:0] fetch_pc, pc_n, bus_addr;
  logic cyc, cyc_n, redirect, term, bus_err, valid, pop, push, space, misaligned;
  logic [CW-1:0] count, count_n;
  entry_t entry, head;
  if_fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (redirect),
    .din    (entry),
    .dout   (head),
    .count  (count)
  );
  always_comb begin
    redirect = pc_control_i != PC_CTRL_SEQ;
    term = cyc && (wbm_ack_if_i || wbm_err_if_i);
    bus_err = cyc && wbm_err_if_i;
    valid = count != '0;
    pop = valid && instr_ready_i && !redirect;
    space = (count - CW'(pop)) < CW'(FIFO_DEPTH);
    misaligned = !cyc && fetch_pc[1:0] != 2'b00 && space;
    push = !redirect && state == FETCH && (term || misaligned);
    entry.instr = (term && !bus_err) ? wbm_dat_if_i : 32'h0;
    entry.pc = fetch_pc;
    entry.trap = !(term && !bus_err);
    entry.code = bus_err ? TRAP_INSTR_ACCESS_FAULT : TRAP_INSTR_MISALIGNED;
    count_n = redirect ? '0 : count + CW'(push) - CW'(pop);
    state_n = state;
    pc_n = fetch_pc;
    if (redirect) begin
      pc_n = ((pc_control_i & PC_CTRL_TRAP) != PC_CTRL_SEQ) ? pc_trap_i : pc_jb_i;
      state_n = (cyc && !term) ? DRAIN : FETCH;
    end else if (state == DRAIN && term) begin
      state_n = FETCH;
    end else if (push) begin
      state_n = entry.trap ? HALT : FETCH;
      pc_n = entry.trap ? fetch_pc : fetch_pc + 32'd4;
    end
    // an open cycle must run to ack/err; a new one starts only if its response is guaranteed a slot
    cyc_n = (cyc && !term) || (state_n == FETCH && pc_n[1:0] == 2'b00 && count_n < CW'(FIFO_DEPTH));
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= FETCH_EN_DEFAULT ? FETCH : IDLE;
      fetch_pc <= RESET_ADDR;
      bus_addr <= RESET_ADDR;
      cyc <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      cyc <= cyc_n;
      if (!(cyc && !term)) bus_addr <= pc_n;
    end
  assign instr_valid_o = valid;
  assign instr_o = valid ? head.instr : 32'h0;
  assign pc_if_o = valid ? head.pc : 32'h0;
  assign pc4_if_o = valid ? head.pc + 32'd4 : 32'h0;
  assign is_trap_if_o = valid && head.trap;
  assign trap_code_if_o = valid ? head.code : 4'h0;
  assign wbm_addr_if_o = bus_addr;
  assign wbm_dat_if_o = 32'h0;
  assign wbm_sel_if_o = 4'b1111;
  assign wbm_cyc_if_o = cyc;
  assign wbm_stb_if_o = cyc;
  assign wbm_we_if_o = 1'b0;
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: scoreboard bench with a wait-state Wishbone slave and a decode-side monitor.
module tb_if_prefetch_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] pc_jb, pc_trap, instr, pc_if, pc4_if, addr, dat_o, dat_in;
  logic [1:0] pc_control;
  logic ready, valid, is_trap, cyc, stb, we, ack, err;
  logic [3:0] trap_code, sel;
  int checks = 0, errors = 0, terms = 0, errs = 0, ws = 0, wcnt = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF, model_pc = 32'h0, drain_addr = 32'h0;
  logic both = 1'b0, drain = 1'b0;
  logic [68:0] want;
  logic [68:0] exp_out [$];
  if_prefetch_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_jb_i(pc_jb), .pc_trap_i(pc_trap), .pc_control_i(pc_control),
    .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(instr), .pc_if_o(pc_if), .pc4_if_o(pc4_if),
    .is_trap_if_o(is_trap), .trap_code_if_o(trap_code), .wbm_addr_if_o(addr), .wbm_dat_if_o(dat_o),
    .wbm_sel_if_o(sel), .wbm_cyc_if_o(cyc), .wbm_stb_if_o(stb), .wbm_we_if_o(we),
    .wbm_dat_if_i(dat_in), .wbm_ack_if_i(ack), .wbm_err_if_i(err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction
  assign dat_in = data_of(addr);
  assign ack = cyc && stb && wcnt >= ws && (addr != err_addr || both);
  assign err = cyc && stb && wcnt >= ws && addr == err_addr;
  always @(posedge clk) wcnt <= (cyc && stb && !(ack || err)) ? wcnt + 1 : 0;
  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference model: expected bus addresses and decode-side entries
  always @(negedge clk) if (rst_n) begin
    if (cyc && (ack || err)) begin
      chk("bus_addr", 69'(addr), 69'(drain ? drain_addr : model_pc));
      terms++;
    end
    if (pc_control != 2'b00) begin
      exp_out.delete();
      if (cyc && !(ack || err)) begin
        if (!drain) drain_addr = model_pc;
        drain = 1'b1;
      end else drain = 1'b0;
      model_pc = (pc_control == 2'b01) ? pc_jb : pc_trap;
    end else begin
      if (valid && ready) begin
        chk("head_present", 69'(exp_out.size() != 0), 69'(1));
        if (exp_out.size() != 0) begin
          want = exp_out.pop_front();
          chk("head_entry", {instr, pc_if, is_trap, trap_code}, want);
          chk("head_pc4", 69'(pc4_if), 69'(want[36:5] + 32'd4));
        end
      end
      if (cyc && (ack || err)) begin
        if (drain) drain = 1'b0;
        else if (err) begin
          exp_out.push_back({32'h0, model_pc, 1'b1, 4'd1});
          errs++;
        end else begin
          exp_out.push_back({data_of(model_pc), model_pc, 1'b0, 4'd0});
          model_pc += 32'd4;
        end
      end
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    exp_out.delete();
    model_pc = 32'h0;
    drain = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_cyc", 69'({cyc, stb}), 69'(3));
    chk("first_addr", 69'(addr), 69'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int base, ncyc;
    bit found;
    rst_n = 1'b0; pc_control = 2'b00; pc_jb = 32'h0; pc_trap = 32'h0; ready = 1'b1;
    #1;
    chk("rst_bus", 69'({cyc, stb, valid, addr}), 69'(0));
    chk("rst_head", {instr, pc_if, is_trap, trap_code}, 69'(0));
    chk("rst_pc4", 69'(pc4_if), 69'(0));
    do_reset();
    base = terms;
    repeat (4) @(negedge clk);
    #1;
    chk("seq_acks", 69'(terms - base), 69'(4));
    chk("seq_valid", 69'(valid), 69'(1));
    repeat (6) @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 69'({cyc, stb, valid}), 69'(0));
    ready = 1'b0;
    do_reset();
    base = terms;
    repeat (12) @(posedge clk);
    #1;
    chk("full_acks", 69'(terms - base), 69'(4));
    chk("full_idle", 69'({cyc, stb}), 69'(0));
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("refill_acks", 69'(terms - base), 69'(5));
    chk("refill_idle", 69'(cyc), 69'(0));
    ready = 1'b1;
    repeat (12) @(posedge clk);
    ws = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1 found = cyc && addr == 32'h8;
    end
    chk("reach_8", 69'(found), 69'(1));
    pc_jb = 32'h100; pc_control = 2'b01;
    @(posedge clk);
    #1 pc_control = 2'b00;
    chk("flush_valid", 69'(valid), 69'(0));
    chk("drain_cyc", 69'(cyc), 69'(1));
    chk("drain_addr", 69'(addr), 69'(32'h8));
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1 found = valid;
    end
    chk("jb_valid", 69'(found), 69'(1));
    chk("jb_pc", 69'(pc_if), 69'(32'h100));
    ws = 0;
    pc_jb = 32'h102; pc_control = 2'b01;
    @(posedge clk);
    #1 pc_control = 2'b00;
    exp_out.push_back({32'h0, 32'h102, 1'b1, 4'd0});
    repeat (3) @(posedge clk);
    #1 base = terms;
    ncyc = 0;
    repeat (8) begin
      @(posedge clk);
      #1 ncyc += int'(cyc);
    end
    chk("halt_nocyc", 69'(ncyc), 69'(0));
    chk("halt_terms", 69'(terms - base), 69'(0));
    chk("mis_popped", 69'(exp_out.size()), 69'(0));
    pc_trap = 32'h200; pc_control = 2'b10;
    @(posedge clk);
    #1 pc_control = 2'b00;
    base = terms;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1 found = terms > base;
    end
    chk("resume", 69'(found), 69'(1));
    err_addr = 32'h40; both = 1'b1;
    pc_jb = 32'h30; pc_control = 2'b01;
    @(posedge clk);
    #1 pc_control = 2'b00;
    base = errs;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1 found = errs > base;
    end
    chk("err_seen", 69'(found), 69'(1));
    base = terms;
    ncyc = 0;
    repeat (8) begin
      @(posedge clk);
      #1 ncyc += int'(cyc);
    end
    chk("err_nocyc", 69'(ncyc), 69'(0));
    chk("err_terms", 69'(terms - base), 69'(0));
    chk("err_popped", 69'(exp_out.size()), 69'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
